// File: rtl/out_mem_drain.sv
// out_mem_drain: streams the output memory to the host in address order (OUT_DRAIN_SAT_EN saturates each word to DATA_WIDTH)
module out_mem_drain #(
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [DATA_WIDTH-1:0]   num_row,
  input  logic [DATA_WIDTH-1:0]   num_out,
  output logic [SYS_COL-1:0]      out_rd_en,
  output logic [ADDR_WIDTH-1:0]   out_rd_addr [0:SYS_COL-1],
  input  logic [2*DATA_WIDTH-1:0] out_rd_data [0:SYS_COL-1],
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [2*DATA_WIDTH-1:0] tx_data [0:SYS_COL-1],
  output logic                    tx_last,
  output logic                    busy,
  output logic                    done
);
  localparam int PSUM_WIDTH = 2*DATA_WIDTH;
  localparam int LOG_COL = $clog2(SYS_COL);
  localparam logic [DATA_WIDTH-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  typedef logic [SYS_COL-1:0][PSUM_WIDTH-1:0] row_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] row_q, row_d, tile_q, tile_d, nrow_q, nrow_d, ntile_q, ntile_d;
  row_t [1:0] mem_q, mem_d;
  logic [1:0] last_q, last_d, occ_q, occ_d;
  logic wp_q, wp_d, rp_q, rp_d, infl_q, infl_d, inl_q, inl_d;
  logic [DATA_WIDTH-1:0] tiles;
  row_t rd_row, head, sat;
  logic rd_en, pop, push, fpop, last_issue, head_last, empty;
  assign tiles = num_out >> LOG_COL;
  assign empty = occ_q == 2'd0;
  assign tx_valid = !empty || infl_q;
  assign head = empty ? rd_row : mem_q[rp_q];
  assign head_last = empty ? inl_q : last_q[rp_q];
  assign pop = tx_valid && tx_ready;
  assign push = infl_q && !(empty && pop);
  assign fpop = pop && !empty;
  assign rd_en = state_q == RUN && ({1'b0, occ_q} + {2'b0, infl_q} < 3'd2 + {2'b0, pop});
  assign last_issue = row_q == nrow_q - ONE && tile_q == ntile_q - ONE;
  assign out_rd_en = {SYS_COL{rd_en}};
  assign tx_last = tx_valid && head_last;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  for (genvar i = 0; i < SYS_COL; i++) begin : g_w
    assign rd_row[i] = out_rd_data[i];
    assign out_rd_addr[i] = addr_q;
    assign tx_data[i] = tx_valid ? sat[i] : '0;
`ifdef OUT_DRAIN_SAT_EN
    logic [DATA_WIDTH:0] top;
    assign top = head[i][PSUM_WIDTH-1:DATA_WIDTH-1];
    assign sat[i] = (&top || ~|top) ? head[i] :
                    top[DATA_WIDTH] ? {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}} :
                                      {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
`else
    assign sat[i] = head[i];
`endif
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    row_d = row_q;
    tile_d = tile_q;
    nrow_d = nrow_q;
    ntile_d = ntile_q;
    mem_d = mem_q;
    last_d = last_q;
    wp_d = push ? ~wp_q : wp_q;
    rp_d = fpop ? ~rp_q : rp_q;
    occ_d = occ_q + {1'b0, push} - {1'b0, fpop};
    infl_d = rd_en;
    inl_d = rd_en && last_issue;
    if (push) begin
      mem_d[wp_q] = rd_row;
      last_d[wp_q] = inl_q;
    end
    case (state_q)
      IDLE: if (start) begin
        addr_d = base_addr;
        row_d = '0;
        tile_d = '0;
        nrow_d = num_row;
        ntile_d = tiles;
        state_d = (num_row == '0 || tiles == '0) ? DONE : RUN;
      end
      RUN: if (rd_en) begin
        addr_d = addr_q + 1'b1;
        tile_d = tile_q == ntile_q - ONE ? '0 : tile_q + ONE;
        row_d = tile_q == ntile_q - ONE ? row_q + ONE : row_q;
        state_d = last_issue ? FLUSH : RUN;
      end
      FLUSH: state_d = ({1'b0, occ_q} + {2'b0, infl_q} == {2'b0, pop}) ? DONE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q <= '0;
      row_q <= '0;
      tile_q <= '0;
      nrow_q <= '0;
      ntile_q <= '0;
      mem_q <= '0;
      last_q <= '0;
      occ_q <= '0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      infl_q <= 1'b0;
      inl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      row_q <= row_d;
      tile_q <= tile_d;
      nrow_q <= nrow_d;
      ntile_q <= ntile_d;
      mem_q <= mem_d;
      last_q <= last_d;
      occ_q <= occ_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      infl_q <= infl_d;
      inl_q <= inl_d;
    end
  end
endmodule

// File: tb/tb_out_mem_drain.sv
// tb_out_mem_drain: directed and random drains checked against an address-order beat model
module tb_out_mem_drain;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] num_row = '0;
  logic [15:0] num_out = '0;
  logic [15:0] out_rd_en;
  logic [15:0] out_rd_addr [0:15];
  logic [31:0] out_rd_data [0:15];
  logic tx_valid;
  logic tx_ready = 1'b0;
  logic [31:0] tx_data [0:15];
  logic tx_last, busy, done;
  logic [31:0] memw [0:255][0:15];
  int errors = 0;
  int checks = 0;
  out_mem_drain dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_row(num_row),
    .num_out(num_out), .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr),
    .out_rd_data(out_rd_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (out_rd_en[0])
      for (int i = 0; i < 16; i++) out_rd_data[i] <= memw[out_rd_addr[0][7:0]][i];
  function automatic logic [31:0] expw(input logic [15:0] a, input int i);
    logic [31:0] w;
    w = memw[a[7:0]][i];
`ifdef OUT_DRAIN_SAT_EN
    if ($signed(w) > 32767) w = 32'h0000_7FFF;
    else if ($signed(w) < -32768) w = 32'hFFFF_8000;
`endif
    return w;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | tx_data[i] | {16'h0, out_rd_addr[i]};
    check({tag, "_data_addr"}, acc, 32'h0);
    check({tag, "_ctl"}, {out_rd_en, 11'h0, tx_valid, tx_last, busy, done}, 32'h0);
  endtask
  task automatic drain(input logic [15:0] base, input logic [15:0] nrow, input logic [15:0] nout,
                       input int mode, input int restart_at, input int abort_after);
    int total, c, issued, popped, bad;
    bit fin, aborted;
    total = int'(nrow) * int'(nout >> 4);
    @(negedge clk);
    base_addr = base;
    num_row = nrow;
    num_out = nout;
    start = 1'b1;
    c = 0; issued = 0; popped = 0; fin = 0; aborted = 0;
    while (!fin) begin
      @(negedge clk);
      c++;
      start = (c == restart_at);
      tx_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 3 == 1) : 1'($urandom % 2);
      #1;
      check("busy", busy, 1);
      if (out_rd_en != 16'h0) begin
        check("rd_en_all", out_rd_en, 16'hFFFF);
        check("rd_addr0", out_rd_addr[0], 16'(base + issued));
        check("rd_addr15", out_rd_addr[15], 16'(base + issued));
        issued++;
      end
      if (tx_valid) begin
        bad = -1;
        for (int i = 15; i >= 0; i--) if (tx_data[i] !== expw(16'(base + popped), i)) bad = i;
        if (bad < 0) check("tx_data", tx_data[0], expw(16'(base + popped), 0));
        else check("tx_data", tx_data[bad], expw(16'(base + popped), bad));
        check("tx_last", tx_last, popped == total - 1);
        if (mode == 0) check("beat_cycle", c, popped + 2);
        if (tx_ready) popped++;
      end else check("tx_last_idle", tx_last, 0);
      check("outstanding", issued - popped <= 2, 1);
      if (abort_after >= 0 && popped == abort_after) begin
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_idle_outputs("abort_reset");
        @(negedge clk);
        rstn = 1'b1;
        fin = 1; aborted = 1;
      end else if (done) begin
        check("done_beats", popped, total);
        check("done_reads", issued, total);
        if (mode == 0) check("done_cycle", c, total == 0 ? 1 : total + 2);
        fin = 1;
      end else if (c > 300) begin
        check("timeout", 0, 1);
        fin = 1;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      @(negedge clk);
      #1;
      check("idle_after", {busy, done, tx_valid}, 3'b000);
    end
  endtask
  initial begin
    for (int a = 0; a < 256; a++)
      for (int i = 0; i < 16; i++) memw[a][i] = $urandom;
    memw[8'h20][0] = 32'h0001_2345;
    memw[8'h20][1] = 32'hFFFF_0000;
    memw[8'h20][2] = 32'h0000_0123;
    memw[8'h20][3] = 32'hFFFF_8000;
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    drain(16'h0000, 16'd4, 16'd32, 0, -1, -1);
    drain(16'h0040, 16'd4, 16'd32, 1, -1, -1);
    drain(16'h0010, 16'd4, 16'd8, 0, -1, -1);
    drain(16'h0010, 16'd0, 16'd32, 0, -1, -1);
    drain(16'h0080, 16'd4, 16'd32, 0, 3, -1);
    drain(16'h0090, 16'd4, 16'd32, 0, -1, 4);
    drain(16'h00A0, 16'd4, 16'd32, 0, -1, -1);
    drain(16'hFFFD, 16'd2, 16'd48, 0, -1, -1);
    drain(16'h0020, 16'd1, 16'd16, 0, -1, -1);
    drain(16'h0020, 16'd1, 16'd16, 1, -1, -1);
    for (int t = 0; t < 12; t++)
      drain(16'($urandom), 16'($urandom_range(0, 3)), 16'($urandom_range(0, 63)), 2, -1, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
